// File: rtl/ram_sp_param_if.sv
// Access bus for ram_sp_param: request, write data/lane mask, registered read data and status.
interface ram_sp_param_if #(
    parameter int DW = 16,
    parameter int AW = 6
) ();
    logic            ce;
    logic            enable;
    logic            r_w;
    logic [AW-1:0]   add;
    logic [DW-1:0]   data_in;
    logic [DW/8-1:0] byte_en;
    logic [DW-1:0]   data_out;
    logic            rd_valid;
    logic            busy;

    modport master (
        output ce, enable, r_w, add, data_in, byte_en,
        input  data_out, rd_valid, busy
    );

    modport slave (
        input  ce, enable, r_w, add, data_in, byte_en,
        output data_out, rd_valid, busy
    );
endinterface

// File: rtl/ram_sp_param.sv
// Parametrised single-port RAM with byte-lane writes, read-valid strobe and post-reset clear sequencer.
// Define RAM_SP_OUTREG_EN to add a ce-gated output register stage (read latency 2).
module ram_sp_param #(
    parameter int            DW             = 16,
    parameter int            AW             = 6,
    parameter int            CLEAR_ON_RESET = 1,
    parameter logic [DW-1:0] CLEAR_VAL      = '0
) (
    input logic           clk,
    input logic           reset,
    ram_sp_param_if.slave bus
);
    localparam int DEPTH = 2 ** AW;
    localparam int NB    = DW / 8;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_e;

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;
    logic [DW-1:0] dout_q;
    logic          rvld_q;

    logic [DW-1:0] mem [DEPTH];

    logic [NB-1:0] lane_we_d;
    logic [AW-1:0] waddr_d;
    logic [DW-1:0] wdata_d;
    logic          rd_req_d;

    // The clear sequencer owns the write port while busy; external requests are dropped.
    always_comb begin
        lane_we_d = '0;
        waddr_d   = '0;
        wdata_d   = '0;
        rd_req_d  = 1'b0;
        if (bus.ce) begin
            if (state_q == ST_CLEAR) begin
                lane_we_d = '1;
                waddr_d   = cnt_q;
                wdata_d   = CLEAR_VAL;
            end else if (bus.enable) begin
                if (bus.r_w) begin
                    lane_we_d = bus.byte_en;
                    waddr_d   = bus.add;
                    wdata_d   = bus.data_in;
                end else begin
                    rd_req_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NB; i++) begin
            if (lane_we_d[i]) begin
                mem[waddr_d][8*i +: 8] <= wdata_d[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= (CLEAR_ON_RESET != 0);
            dout_q  <= '0;
            rvld_q  <= 1'b0;
        end else if (bus.ce) begin
            rvld_q <= rd_req_d;
            if (rd_req_d) begin
                dout_q <= mem[bus.add];
            end
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RAM_SP_OUTREG_EN
    logic [DW-1:0] dout2_q;
    logic          rvld2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout2_q <= '0;
            rvld2_q <= 1'b0;
        end else if (bus.ce) begin
            dout2_q <= dout_q;
            rvld2_q <= rvld_q;
        end
    end

    assign bus.data_out = dout2_q;
    assign bus.rd_valid = rvld2_q;
`else
    assign bus.data_out = dout_q;
    assign bus.rd_valid = rvld_q;
`endif

    assign bus.busy = busy_q;
endmodule

// File: tb/tb_ram_sp_param.sv
// Directed bench for ram_sp_param with a read scoreboard checking data and ce-cycle latency.
module tb_ram_sp_param;
    localparam int DW = 16;
    localparam int AW = 6;
`ifdef RAM_SP_OUTREG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_sp_param_if #(.DW(DW), .AW(AW)) bus ();

    ram_sp_param #(
        .DW(DW),
        .AW(AW),
        .CLEAR_ON_RESET(1),
        .CLEAR_VAL(16'h0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned ce_cnt   = 0;
    exp_t        sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [DW-1:0] d);
        exp_t e;
        e.data = d;
        e.due  = ce_cnt + LAT;
        sb.push_back(e);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        bus.enable  = 1'b1;
        bus.r_w     = 1'b1;
        bus.add     = a;
        bus.data_in = d;
        bus.byte_en = be;
        tick();
        bus.enable  = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
        push_exp(d);
        bus.enable = 1'b1;
        bus.r_w    = 1'b0;
        bus.add    = a;
        tick();
        bus.enable = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    // Scoreboard monitor: every ce-qualified edge either delivers the head entry on time or nothing.
    always begin
        logic ce_s;
        exp_t e;
        @(posedge clk);
        ce_s = bus.ce;
        if (ce_s) ce_cnt++;
        #1;
        if (ce_s && !reset) begin
            if (bus.rd_valid) begin
                chk("rd_valid_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rd_data", bus.data_out, e.data);
                    chk("rd_latency", ce_cnt, e.due);
                end
            end else if (sb.size() != 0 && sb[0].due <= ce_cnt) begin
                e = sb.pop_front();
                chk("rd_valid_missing", bus.rd_valid, 1);
            end
        end
    end

    initial begin
        int unsigned n;
        reset       = 1'b1;
        bus.ce      = 1'b1;
        bus.enable  = 1'b0;
        bus.r_w     = 1'b0;
        bus.add     = '0;
        bus.data_in = '0;
        bus.byte_en = '0;
        repeat (3) tick();
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_busy", bus.busy, 1);

        // Clear after reset, with a write and a read attempted while busy
        reset = 1'b0;
        n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
            if (n == 10) begin
                bus.enable  = 1'b1;
                bus.r_w     = 1'b1;
                bus.add     = 7;
                bus.data_in = 16'hAAAA;
                bus.byte_en = 2'b11;
            end
            if (n == 12) bus.r_w = 1'b0;
            if (n == 14) bus.enable = 1'b0;
        end
        chk("clear_len", n, 64);
        rd(5, 16'h0000);
        rd(7, 16'h0000);
        drain();

        // Byte lanes
        wr(3, 16'hBEEF, 2'b11);
        chk("wr_no_rd_valid", bus.rd_valid, 0);
        wr(3, 16'h0012, 2'b01);
        rd(3, 16'hBE12);
        drain();

        // ce stall with a pending read; rd_valid is frozen high from the last read
        rd(5, 16'h0000);
        drain();
        bus.ce     = 1'b0;
        bus.enable = 1'b1;
        bus.r_w    = 1'b0;
        bus.add    = 3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_data_out", bus.data_out, 16'h0000);
            chk("stall_rd_valid", bus.rd_valid, 1);
        end
        push_exp(16'hBE12);
        bus.ce = 1'b1;
        tick();
        bus.enable = 1'b0;
        drain();
        chk("stall_release_data", bus.data_out, 16'hBE12);

        wr(3, 16'hFFFF, 2'b00);
        wr(3, 16'h5600, 2'b10);
        rd(3, 16'h5612);
        drain();

        // Async reset clears outputs immediately, then a mid-clear reset restarts the sequence
        reset = 1'b1;
        #1;
        chk("async_rst_data_out", bus.data_out, 16'h0000);
        chk("async_rst_busy", bus.busy, 1);
        tick();
        reset = 1'b0;
        repeat (20) tick();
        chk("midclear_busy", bus.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        chk("midclear_len", n, 64);
        chk("midclear_data_out", bus.data_out, 16'h0000);

        // Pipelined read stream
        for (int i = 0; i < 4; i++) wr(AW'(i), DW'(i + 1), 2'b11);
        for (int i = 0; i < 4; i++) begin
            push_exp(DW'(i + 1));
            bus.enable = 1'b1;
            bus.r_w    = 1'b0;
            bus.add    = AW'(i);
            tick();
        end
        bus.enable = 1'b0;
        drain();
        rd(3, 16'h0004);
        drain();

        // Clear with a 5-cycle ce stall: counter must freeze
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        while (bus.busy && n < 200) begin
            if (n == 30) bus.ce = 1'b0;
            if (n == 35) bus.ce = 1'b1;
            tick();
            n++;
            if (n == 34) chk("stall_clear_busy", bus.busy, 1);
        end
        chk("stall_clear_len", n, 69);
        rd(3, 16'h0000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
